rf_access_bridge: RTL and testbench

RF_ACCESS_BRIDGE -- requirements
Module: rf_access_bridge

---
 rtl/rf_bridge_pkg.sv | 20 ++
 rtl/rf_bridge_timer.sv | 27 ++
 rtl/rf_access_bridge.sv | 141 ++++++++++++++
 tb/tb_rf_access_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_bridge_pkg.sv
// rtl/rf_bridge_pkg.sv - shared types for the register-file access bridge
package rf_bridge_pkg;

  localparam int STATUS_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK           = 2'b00,
    ST_INVALID_ADDR = 2'b01,
    ST_MISALIGNED   = 2'b10,
    ST_TIMEOUT      = 2'b11
  } status_e;

endpackage

// File: rtl/rf_bridge_timer.sv
// rtl/rf_bridge_timer.sv - wait-cycle counter that flags the last allowed WAIT cycle
module rf_bridge_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (res || clear) begin
      r_count <= 8'd0;
    end else if (enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Only meaningful while counting, so an idle counter never reports expiry.
  assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/rf_access_bridge.sv
// rtl/rf_access_bridge.sv - host command to register-file access bridge
// One outstanding access: accept, strobe once, wait for completion or timeout, respond.
module rf_access_bridge
  import rf_bridge_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic [ADDR_W-4:0] rf_address,
  output logic              rf_read_en,
  output logic              rf_write_en,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data,
  input  logic              rf_invalid_address,
  input  logic              rf_access_complete
);

  state_e              r_state;
  state_e              w_next;
  logic                r_write;
  logic [ADDR_W-4:0]   r_rf_address;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic [DATA_W-1:0]   r_rsp_rdata;
  status_e             r_rsp_status;

  logic                w_load_cmd;
  logic                w_load_rsp;
  status_e             w_rsp_status;
  logic [DATA_W-1:0]   w_rsp_rdata;
  logic                w_tmr_clear;
  logic                w_tmr_en;
  logic                w_expired;

  rf_bridge_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .res     (res),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_load_cmd   = 1'b0;
    w_load_rsp   = 1'b0;
    w_rsp_status = ST_OK;
    w_rsp_rdata  = '0;
    w_tmr_clear  = 1'b0;
    w_tmr_en     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr[2:0] != 3'b000) begin
            w_next       = S_RESP;
            w_load_rsp   = 1'b1;
            w_rsp_status = ST_MISALIGNED;
          end else begin
            w_next     = S_ISSUE;
            w_load_cmd = 1'b1;
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        w_tmr_clear = (r_state == S_ISSUE);
        w_tmr_en    = (r_state == S_WAIT);
        // Completion is checked before expiry so a same-cycle completion wins.
        if (rf_access_complete) begin
          w_next     = S_RESP;
          w_load_rsp = 1'b1;
          if (rf_invalid_address) begin
            w_rsp_status = ST_INVALID_ADDR;
          end else if (!r_write) begin
            w_rsp_rdata = rf_read_data;
          end
        end else if (w_expired) begin
          w_next       = S_RESP;
          w_load_rsp   = 1'b1;
          w_rsp_status = ST_TIMEOUT;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_write      <= 1'b0;
      r_rf_address <= '0;
      r_rf_wdata   <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= ST_OK;
    end else begin
      if (w_load_cmd) begin
        r_write      <= cmd_write;
        r_rf_address <= cmd_addr[ADDR_W-1:3];
        r_rf_wdata   <= cmd_wdata;
      end
      if (w_load_rsp) begin
        r_rsp_rdata  <= w_rsp_rdata;
        r_rsp_status <= w_rsp_status;
      end
    end
  end

  assign cmd_ready     = (r_state == S_IDLE) && !res;
  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_status    = r_rsp_status;
  assign rf_address    = r_rf_address;
  assign rf_write_data = r_rf_wdata;
  assign rf_write_en   = (r_state == S_ISSUE) && r_write;
  assign rf_read_en    = (r_state == S_ISSUE) && !r_write;

endmodule

// File: tb/tb_rf_access_bridge.sv
// tb/tb_rf_access_bridge.sv - directed self-checking bench for rf_access_bridge
module tb_rf_access_bridge;

  logic        clk = 1'b0;
  logic        res;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [4:0]  rf_address;
  logic        rf_read_en;
  logic        rf_write_en;
  logic [63:0] rf_write_data;
  logic [63:0] rf_read_data;
  logic        rf_invalid_address;
  logic        rf_access_complete;

  int total = 0;
  int bad   = 0;
  int n_wr  = 0;
  int n_rd  = 0;

  rf_access_bridge #(.ADDR_W(8), .DATA_W(64), .TIMEOUT(16)) dut (
    .clk                (clk),
    .res                (res),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_write          (cmd_write),
    .cmd_addr           (cmd_addr),
    .cmd_wdata          (cmd_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_rdata          (rsp_rdata),
    .rsp_status         (rsp_status),
    .rf_address         (rf_address),
    .rf_read_en         (rf_read_en),
    .rf_write_en        (rf_write_en),
    .rf_write_data      (rf_write_data),
    .rf_read_data       (rf_read_data),
    .rf_invalid_address (rf_invalid_address),
    .rf_access_complete (rf_access_complete)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_write_en) n_wr <= n_wr + 1;
    if (rf_read_en)  n_rd <= n_rd + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; rf_read_data = '0; rf_invalid_address = 1'b0; rf_access_complete = 1'b0;
    repeat (3) tick();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if ({rf_read_en, rf_write_en} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {rf_read_en, rf_write_en}); end
    total++; if (rf_address !== 5'd0 || rf_write_data !== 64'd0) begin bad++; $display("FAIL reset_rf_regs addr=%h data=%h exp=0", rf_address, rf_write_data); end
    total++; if (rsp_rdata !== 64'd0 || rsp_status !== 2'b00) begin bad++; $display("FAIL reset_rsp rdata=%h status=%b exp=0/00", rsp_rdata, rsp_status); end
    total++; if (dut.u_timer.r_count !== 8'd0) begin bad++; $display("FAIL reset_counter got=%0d exp=0", dut.u_timer.r_count); end
    res = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write_issue();
    int wr0 = n_wr;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 64'h20;
    tick();
    cmd_valid = 1'b0;
    total++; if (rf_write_en !== 1'b1 || rf_read_en !== 1'b0) begin bad++; $display("FAIL wr_strobe we=%b re=%b exp=1/0", rf_write_en, rf_read_en); end
    total++; if (rf_address !== 5'd4 || rf_write_data !== 64'h20) begin bad++; $display("FAIL wr_addr_data addr=%h data=%h exp=4/20", rf_address, rf_write_data); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_early_rsp got=%b exp=0", rsp_valid); end
    rf_access_complete = 1'b1;
    tick();
    rf_access_complete = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00) begin bad++; $display("FAIL wr_rsp valid=%b status=%b exp=1/00", rsp_valid, rsp_status); end
    total++; if (rsp_rdata !== 64'd0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rsp_rdata); end
    total++; if (n_wr - wr0 !== 1) begin bad++; $display("FAIL wr_pulses got=%0d exp=1", n_wr - wr0); end
    // Next command presented while the response is being taken.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h21; rsp_ready = 1'b1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_resp got=%b exp=0", cmd_ready); end
    tick();
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle valid=%b ready=%b exp=0/1", rsp_valid, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b10) begin bad++; $display("FAIL b2b_second valid=%b status=%b exp=1/10", rsp_valid, rsp_status); end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_read_wait();
    int rd0 = n_rd;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h28;
    tick();
    cmd_valid = 1'b0;
    total++; if (rf_read_en !== 1'b1 || rf_address !== 5'd5) begin bad++; $display("FAIL rd_strobe re=%b addr=%h exp=1/5", rf_read_en, rf_address); end
    tick();
    tick();
    total++; if (rf_address !== 5'd5 || rf_read_en !== 1'b0) begin bad++; $display("FAIL rd_wait addr=%h re=%b exp=5/0", rf_address, rf_read_en); end
    tick();
    rf_access_complete = 1'b1; rf_read_data = 64'hDEAD;
    tick();
    rf_access_complete = 1'b0; rf_read_data = 64'h1111;
    total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 64'hDEAD) begin bad++; $display("FAIL rd_rsp valid=%b status=%b rdata=%h exp=1/00/dead", rsp_valid, rsp_status, rsp_rdata); end
    total++; if (n_rd - rd0 !== 1) begin bad++; $display("FAIL rd_pulses got=%0d exp=1", n_rd - rd0); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    int s0 = n_rd + n_wr;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h2C;
    tick();
    cmd_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_rdata !== 64'd0) begin bad++; $display("FAIL mis_rsp valid=%b status=%b rdata=%h exp=1/10/0", rsp_valid, rsp_status, rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (n_rd + n_wr - s0 !== 0) begin bad++; $display("FAIL mis_no_strobe got=%0d exp=0", n_rd + n_wr - s0); end
  endtask

  task automatic test_timeout();
    int quiet;
    // Pass 0: no completion at all. Pass 1: completion on the last WAIT cycle.
    for (int pass = 0; pass < 2; pass++) begin
      quiet = 0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (rsp_valid === 1'b0) quiet++;
      end
      if (pass == 1) begin
        rf_access_complete = 1'b1; rf_read_data = 64'h1234;
      end
      tick();
      rf_access_complete = 1'b0;
      total++; if (quiet !== 16) begin bad++; $display("FAIL to_quiet pass=%0d got=%0d exp=16", pass, quiet); end
      if (pass == 0) begin
        total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b11 || rsp_rdata !== 64'd0) begin bad++; $display("FAIL to_expire valid=%b status=%b rdata=%h exp=1/11/0", rsp_valid, rsp_status, rsp_rdata); end
      end else begin
        total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 64'h1234) begin bad++; $display("FAIL to_race valid=%b status=%b rdata=%h exp=1/00/1234", rsp_valid, rsp_status, rsp_rdata); end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_invalid_hold();
    int unstable = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40;
    tick();
    cmd_valid = 1'b0;
    rf_access_complete = 1'b1; rf_invalid_address = 1'b1; rf_read_data = 64'hFFFF;
    tick();
    rf_access_complete = 1'b0; rf_invalid_address = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_rdata !== 64'd0) begin bad++; $display("FAIL inv_rsp valid=%b status=%b rdata=%h exp=1/01/0", rsp_valid, rsp_status, rsp_rdata); end
    for (int i = 0; i < 5; i++) begin
      rf_access_complete = i[0]; rf_read_data = 64'hABC0 + 64'(i);
      tick();
      if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_rdata !== 64'd0 || cmd_ready !== 1'b0) unstable++;
    end
    rf_access_complete = 1'b0;
    total++; if (unstable !== 0) begin bad++; $display("FAIL inv_hold unstable_cycles=%0d exp=0", unstable); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL inv_release got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    res = 1'b1;
    tick();
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || rf_read_en !== 1'b0) begin bad++; $display("FAIL mid_reset valid=%b ready=%b re=%b exp=0/0/0", rsp_valid, cmd_ready, rf_read_en); end
    res = 1'b0;
    rf_access_complete = 1'b1;
    tick();
    rf_access_complete = 1'b0;
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL stray_complete valid=%b ready=%b exp=0/1", rsp_valid, cmd_ready); end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h38; cmd_wdata = 64'hA5;
    tick();
    cmd_valid = 1'b0;
    total++; if (rf_write_en !== 1'b1 || rf_address !== 5'd7 || rf_write_data !== 64'hA5) begin bad++; $display("FAIL post_wr we=%b addr=%h data=%h exp=1/7/a5", rf_write_en, rf_address, rf_write_data); end
    tick();
    rf_access_complete = 1'b1;
    tick();
    rf_access_complete = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00) begin bad++; $display("FAIL post_rsp valid=%b status=%b exp=1/00", rsp_valid, rsp_status); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_issue();
    test_read_wait();
    test_misaligned();
    test_timeout();
    test_invalid_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
